tick_prescaler: RTL and testbench



---
 rtl/tick_prescaler.sv | 111 +++++++++++
 tb/tb_tick_prescaler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_prescaler.sv
// Programmable enable-tick generator: divides clk by a run-time divisor and emits
// single-cycle tick pulses, either continuously or as a finite burst.
module tick_prescaler #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] burst,
   input  logic             start,
   input  logic             stop,
   output logic             tick,
   output logic             busy,
   output logic             done
);

   // state   | meaning
   // --------+--------------------------------------------------------
   // ST_IDLE | no run in progress; outputs quiet, waiting for start
   // ST_RUN  | prescaler counting; tick on each period boundary

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] period_q, period_d;
   logic [DIV_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             cont_q, cont_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [DIV_W-1:0] div_eff;

   assign div_eff = (div == '0) ? DIV_W'(1) : div;

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      pc_d        = pc_q;
      remaining_d = remaining_q;
      cont_d      = cont_q;
      tick_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d     = ST_RUN;
               period_d    = div_eff;
               remaining_d = burst;
               cont_d      = (burst == '0);
               pc_d        = '0;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               pc_d    = '0;
            end else if (pc_q == period_q - DIV_W'(1)) begin
               tick_d   = 1'b1;
               pc_d     = '0;
               // divisor only re-sampled here so no interval is ever truncated
               period_d = div_eff;
               if (!cont_q) begin
                  remaining_d = remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               pc_d = pc_q + DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         period_q    <= DIV_W'(1);
         pc_q        <= '0;
         remaining_q <= '0;
         cont_q      <= 1'b0;
         tick_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         pc_q        <= pc_d;
         remaining_q <= remaining_d;
         cont_q      <= cont_d;
         tick_q      <= tick_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign tick = tick_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Directed testbench for tick_prescaler; a small mod-128 counter model rides on tick.
module tb_tick_prescaler;

   localparam int DIV_W = 16;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [DIV_W-1:0] div = '0;
   logic [CNT_W-1:0] burst = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             tick, busy, done;

   int n_checks = 0;
   int n_fail = 0;

   logic [6:0] cnt;
   logic       cnt_clr = 1'b0;
   int         co_seen;

   tick_prescaler #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .div(div), .burst(burst),
      .start(start), .stop(stop), .tick(tick), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // downstream mod-128 counter driven by tick as its enable
   always @(posedge clk) begin
      if (cnt_clr) begin
         cnt     <= '0;
         co_seen <= 0;
      end else if (tick) begin
         cnt <= cnt + 7'd1;
         if (cnt == 7'd127) co_seen <= co_seen + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      n_checks++;
      if ({tick, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_initial: tick/busy/done=%b expected 000", {tick, busy, done});
      end
      rst = 1'b0;
      div = 16'd7; burst = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 7; n++) step();
      n_checks++;
      if ({tick, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_pre_tick: tick/busy=%b expected 11", {tick, busy});
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({tick, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_async: tick/busy/done=%b expected 000", {tick, busy, done});
      end
      #1 rst = 1'b0;
      begin
         int bad = 0;
         for (int n = 0; n < 12; n++) begin
            step();
            if (tick !== 1'b0 || busy !== 1'b0) bad++;
         end
         n_checks++;
         if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_after: %0d active cycles, expected 0", bad);
         end
      end
   endtask

   task automatic test_finite_burst();
      div = 16'd5; burst = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      n_checks++;
      if ({tick, busy, done} !== 3'b010) begin
         n_fail++;
         $display("FAIL burst_busy_rise: tick/busy/done=%b expected 010", {tick, busy, done});
      end
      for (int n = 1; n <= 18; n++) begin
         logic et, eb, ed;
         step();
         et = (n % 5 == 0) && (n <= 15);
         ed = (n == 15);
         eb = (n < 15);
         n_checks++;
         if ({tick, busy, done} !== {et, eb, ed}) begin
            n_fail++;
            $display("FAIL burst_cycle%0d: tick/busy/done=%b expected %b", n, {tick, busy, done}, {et, eb, ed});
         end
      end
   endtask

   task automatic test_continuous_div0();
      int done_cnt = 0;
      int tick_cnt = 0;
      div = 16'd0; burst = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         step();
         if (tick === 1'b1) tick_cnt++;
         if (done !== 1'b0) done_cnt++;
      end
      n_checks++;
      if (tick_cnt !== 8) begin
         n_fail++;
         $display("FAIL cont_div0_ticks: %0d ticks in 8 cycles, expected 8", tick_cnt);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_checks++;
      if ({tick, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL cont_stop: tick/busy=%b expected 00", {tick, busy});
      end
      for (int n = 0; n < 4; n++) begin
         step();
         if (done !== 1'b0 || tick !== 1'b0) done_cnt++;
      end
      n_checks++;
      if (done_cnt !== 0) begin
         n_fail++;
         $display("FAIL cont_no_done: %0d stray done/tick cycles, expected 0", done_cnt);
      end
   endtask

   task automatic test_div_change();
      int bad = 0;
      div = 16'd4; burst = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         logic et;
         step();
         if (n == 5) div = 16'd2;
         et = (n == 4) || (n == 8) || (n == 10) || (n == 12) || (n == 14);
         if (tick !== et) begin
            bad++;
            $display("FAIL div_change_cycle%0d: tick=%b expected %b", n, tick, et);
         end
      end
      n_checks++;
      if (bad !== 0) n_fail++;
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL div_change_stop: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_priority();
      int bad = 0;
      // start while busy must not restart the prescaler
      div = 16'd3; burst = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         logic et;
         step();
         start = (n == 4);
         et = (n % 3 == 0);
         if (tick !== et) bad++;
      end
      start = 1'b0;
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL prio_start_busy: %0d spacing errors, expected 0", bad);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      // stop on the tick-due edge
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_checks++;
      if ({tick, busy, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL prio_stop_on_tick: tick/busy/done=%b expected 000", {tick, busy, done});
      end
      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_start_stop_idle: busy=%b expected 0", busy);
      end
      bad = 0;
      for (int n = 0; n < 6; n++) begin
         step();
         if (tick !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL prio_idle_hold: %0d active cycles, expected 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      div = 16'd2; burst = 8'd1; start = 1'b1;
      step();
      for (int n = 1; n <= 6; n++) begin
         logic et, ed, eb;
         step();
         // start held: each done cycle is followed by an immediate relaunch
         et = (n == 2) || (n == 5);
         ed = et;
         eb = !et;
         if ({tick, busy, done} !== {et, eb, ed}) bad++;
      end
      start = 1'b0;
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL back_to_back: %0d cycle errors, expected 0", bad);
      end
      step(); step();
   endtask

   task automatic test_integration();
      int bad = 0;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      div = 16'd3; burst = 8'd128; start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 390; n++) begin
         logic et, ed;
         step();
         et = (n % 3 == 0) && (n <= 384);
         ed = (n == 384);
         if (tick !== et || done !== ed) bad++;
         if (n == 30) begin
            n_checks++;
            if (cnt !== 7'd9) begin
               n_fail++;
               $display("FAIL integ_cnt_at30: cnt=%0d expected 9", cnt);
            end
         end
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL integ_tick_pattern: %0d cycle errors, expected 0", bad);
      end
      n_checks++;
      if (co_seen !== 1) begin
         n_fail++;
         $display("FAIL integ_co_count: %0d carries, expected 1", co_seen);
      end
      for (int n = 0; n < 10; n++) step();
      n_checks++;
      if (cnt !== 7'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL integ_hold: cnt=%0d busy=%b expected 0/0", cnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_finite_burst();
      test_continuous_div0();
      test_div_change();
      test_priority();
      test_back_to_back();
      test_integration();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
